// File: rtl/blob_bbox_pkg.sv
// Shared types and constants for the blob bounding-box scanner.
// Optional centroid sums are enabled with the BBOX_CENTROID_EN macro.
package blob_bbox_pkg;

    localparam int unsigned IMG_W_DEF = 320;
    localparam int unsigned IMG_H_DEF = 240;
    localparam int unsigned PIX_TOTAL = IMG_W_DEF * IMG_H_DEF;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned SUM_W     = 25;
    localparam logic [7:0]  FG_ZERO   = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH,
        DONE
    } state_t;

endpackage

// File: rtl/bbox_raster_cnt.sv
// Raster-order x/y/address generator with last flag and the (x, y, valid)
// triple delayed one cycle to line up with synchronous SRAM read data.
module bbox_raster_cnt
    import blob_bbox_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned XW    = 9,
    parameter int unsigned YW    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c,
    output logic [XW-1:0]     d_x,
    output logic [YW-1:0]     d_y,
    output logic              d_valid
);

    localparam int unsigned PIX_N = IMG_W * IMG_H;

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    assign last_c = (addr == ADDR_W'(PIX_N - 1));

    // The address holds at the final pixel once it has been issued.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            addr    <= '0;
            x       <= '0;
            y       <= '0;
            d_x     <= '0;
            d_y     <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= en;
            d_x     <= x;
            d_y     <= y;
            if (clr) begin
                addr <= '0;
                x    <= '0;
                y    <= '0;
            end else if (en && !last_c) begin
                addr <= addr + ADDR_W'(1);
                if (x == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/blob_bbox_scan.sv
// Scans the thresholded image in SRAM_B for foreground pixel count and bounding box.
// Define BBOX_CENTROID_EN to add the Sum_X / Sum_Y coordinate sums.
module blob_bbox_scan
    import blob_bbox_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned XW    = 9,
    parameter int unsigned YW    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Go_s,
    output logic              Done_s,
    output logic [ADDR_W-1:0] MB_Addr17_2,
    output logic              MB_ena,
    output logic              MB_wea,
    output logic [7:0]        MB_di8_2,
    input  logic [7:0]        MB_do8_2,
    output logic [ADDR_W-1:0] Pix_Cnt,
    output logic [XW-1:0]     X_Min,
    output logic [XW-1:0]     X_Max,
    output logic [YW-1:0]     Y_Min,
    output logic [YW-1:0]     Y_Max,
    output logic              Obj_Valid
`ifdef BBOX_CENTROID_EN
    ,
    output logic [SUM_W-1:0]  Sum_X,
    output logic [SUM_W-1:0]  Sum_Y
`endif
);

    state_t state_q, state_d;
    logic   start_c, finish_c;

    logic              last_c;
    logic [XW-1:0]     d_x;
    logic [YW-1:0]     d_y;
    logic              d_valid;
    logic              fg_c;

    logic [ADDR_W-1:0] cnt_q;
    logic [XW-1:0]     xmin_q, xmax_q;
    logic [YW-1:0]     ymin_q, ymax_q;
`ifdef BBOX_CENTROID_EN
    logic [SUM_W-1:0]  sumx_q, sumy_q;
`endif

    assign MB_wea   = 1'b0;
    assign MB_di8_2 = '0;
    assign fg_c     = d_valid && (MB_do8_2 != FG_ZERO);

    bbox_raster_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW)
    ) u_raster (
        .Clk     (Clk),
        .Rst     (Rst),
        .clr     (start_c),
        .en      (MB_ena),
        .addr    (MB_Addr17_2),
        .last_c  (last_c),
        .d_x     (d_x),
        .d_y     (d_y),
        .d_valid (d_valid)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            MB_ena  <= 1'b0;
            Done_s  <= 1'b0;
        end else begin
            state_q <= state_d;
            MB_ena  <= (state_d == READ);
            Done_s  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (Go_s) begin
                    start_c = 1'b1;
                    state_d = READ;
                end
            end
            READ:   if (last_c) state_d = DRAIN;
            DRAIN:  state_d = FINISH;
            FINISH: begin
                finish_c = 1'b1;
                state_d  = DONE;
            end
            DONE:   if (!Go_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Data-stage accumulators; min starts all-ones so the first pixel always wins.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q  <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
`ifdef BBOX_CENTROID_EN
            sumx_q <= '0;
            sumy_q <= '0;
`endif
        end else if (start_c) begin
            cnt_q  <= '0;
            xmin_q <= '1;
            xmax_q <= '0;
            ymin_q <= '1;
            ymax_q <= '0;
`ifdef BBOX_CENTROID_EN
            sumx_q <= '0;
            sumy_q <= '0;
`endif
        end else if (fg_c) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (d_x < xmin_q) xmin_q <= d_x;
            if (d_x > xmax_q) xmax_q <= d_x;
            if (d_y < ymin_q) ymin_q <= d_y;
            if (d_y > ymax_q) ymax_q <= d_y;
`ifdef BBOX_CENTROID_EN
            sumx_q <= sumx_q + SUM_W'(d_x);
            sumy_q <= sumy_q + SUM_W'(d_y);
`endif
        end
    end

    // Results only change in FINISH; an empty image reports a zero box.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Pix_Cnt   <= '0;
            X_Min     <= '0;
            X_Max     <= '0;
            Y_Min     <= '0;
            Y_Max     <= '0;
            Obj_Valid <= 1'b0;
`ifdef BBOX_CENTROID_EN
            Sum_X     <= '0;
            Sum_Y     <= '0;
`endif
        end else if (finish_c) begin
            Pix_Cnt   <= cnt_q;
            Obj_Valid <= (cnt_q != '0);
            X_Min     <= (cnt_q == '0) ? '0 : xmin_q;
            X_Max     <= (cnt_q == '0) ? '0 : xmax_q;
            Y_Min     <= (cnt_q == '0) ? '0 : ymin_q;
            Y_Max     <= (cnt_q == '0) ? '0 : ymax_q;
`ifdef BBOX_CENTROID_EN
            Sum_X     <= sumx_q;
            Sum_Y     <= sumy_q;
`endif
        end
    end

endmodule

// File: tb/tb_blob_bbox_scan.sv
// Directed bench for blob_bbox_scan on a reduced 20x12 image with a 1-cycle SRAM model.
// Sum checks are included when BBOX_CENTROID_EN is defined.
module tb_blob_bbox_scan;

    localparam int unsigned W  = 20;
    localparam int unsigned H  = 12;
    localparam int unsigned XW = 5;
    localparam int unsigned YW = 4;
    localparam int unsigned N  = W * H;
    localparam int LAT = N + 3;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Go_s;
    logic        Done_s;
    logic [16:0] MB_Addr17_2;
    logic        MB_ena;
    logic        MB_wea;
    logic [7:0]  MB_di8_2;
    logic [7:0]  MB_do8_2;
    logic [16:0] Pix_Cnt;
    logic [XW-1:0] X_Min, X_Max;
    logic [YW-1:0] Y_Min, Y_Max;
    logic        Obj_Valid;
`ifdef BBOX_CENTROID_EN
    logic [24:0] Sum_X, Sum_Y;
`endif

    logic [7:0] mem [0:N-1];
    int n_cmp = 0;
    int n_err = 0;
    int lat;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MB_ena && (MB_Addr17_2 < 17'(N)))
            MB_do8_2 <= mem[int'(MB_Addr17_2)];
    end

    blob_bbox_scan #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Go_s        (Go_s),
        .Done_s      (Done_s),
        .MB_Addr17_2 (MB_Addr17_2),
        .MB_ena      (MB_ena),
        .MB_wea      (MB_wea),
        .MB_di8_2    (MB_di8_2),
        .MB_do8_2    (MB_do8_2),
        .Pix_Cnt     (Pix_Cnt),
        .X_Min       (X_Min),
        .X_Max       (X_Max),
        .Y_Min       (Y_Min),
        .Y_Max       (Y_Max),
        .Obj_Valid   (Obj_Valid)
`ifdef BBOX_CENTROID_EN
        ,
        .Sum_X       (Sum_X),
        .Sum_Y       (Sum_Y)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < int'(N); i++) mem[i] = v;
    endtask

    task automatic chk_box(input string tag, input int cnt, input int x0, input int y0,
                           input int x1, input int y1);
        chk({tag, "_cnt"},   32'(Pix_Cnt),   32'(cnt));
        chk({tag, "_valid"}, 32'(Obj_Valid), 32'(cnt != 0));
        chk({tag, "_xmin"},  32'(X_Min),     32'(x0));
        chk({tag, "_xmax"},  32'(X_Max),     32'(x1));
        chk({tag, "_ymin"},  32'(Y_Min),     32'(y0));
        chk({tag, "_ymax"},  32'(Y_Max),     32'(y1));
    endtask

    // Starts a scan and returns edges from the Go-sampling edge until Done_s is seen high.
    task automatic run_scan(input bit hold, input int pulse_at, input int mid_cnt,
                            output int latency);
        int cnt;
        cnt = 0;
        latency = -1;
        @(negedge Clk);
        Go_s = 1'b1;
        while (cnt < int'(2 * N + 50)) begin
            @(posedge Clk);
            #1;
            cnt++;
            if (!hold && cnt == 1) Go_s = 1'b0;
            if (pulse_at > 0 && cnt == pulse_at) Go_s = 1'b1;
            if (pulse_at > 0 && cnt == pulse_at + 2) Go_s = 1'b0;
            if (mid_cnt >= 0 && cnt == 100) chk("hold_during_scan", 32'(Pix_Cnt), 32'(mid_cnt));
            if (Done_s) begin
                latency = cnt;
                break;
            end
        end
    endtask

    task automatic finish_scan(input string tag);
        @(posedge Clk);
        #1;
        chk({tag, "_done_fall"}, 32'(Done_s), 32'd0);
    endtask

    initial begin
        Rst  = 1'b1;
        Go_s = 1'b0;
        fill(8'h00);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_done", 32'(Done_s), 32'd0);
        chk("rst_ena",  32'(MB_ena), 32'd0);
        chk("rst_wea",  32'(MB_wea), 32'd0);
        chk_box("rst", 0, 0, 0, 0, 0);
        @(negedge Clk);
        Rst = 1'b0;

        // Empty image: latency and forced-zero box
        run_scan(1'b0, 0, -1, lat);
        chk("zero_latency", 32'(lat), 32'(LAT));
        chk_box("zero", 0, 0, 0, 0, 0);
`ifdef BBOX_CENTROID_EN
        chk("zero_sumx", 32'(Sum_X), 32'd0);
        chk("zero_sumy", 32'(Sum_Y), 32'd0);
`endif
        finish_scan("zero");

        // Single pixel at x=1, y=1
        mem[W + 1] = 8'hFF;
        run_scan(1'b0, 0, 0, lat);
        chk("single_latency", 32'(lat), 32'(LAT));
        chk_box("single", 1, 1, 1, 1, 1);
`ifdef BBOX_CENTROID_EN
        chk("single_sumx", 32'(Sum_X), 32'd1);
        chk("single_sumy", 32'(Sum_Y), 32'd1);
`endif
        finish_scan("single");

        // Rectangle x 10..19, y 5..9; old result must hold mid-scan
        fill(8'h00);
        for (int y = 5; y <= 9; y++)
            for (int x = 10; x <= 19; x++)
                mem[y * int'(W) + x] = 8'hFF;
        run_scan(1'b0, 0, 1, lat);
        chk_box("rect", 50, 10, 5, 19, 9);
`ifdef BBOX_CENTROID_EN
        chk("rect_sumx", 32'(Sum_X), 32'd725);
        chk("rect_sumy", 32'(Sum_Y), 32'd350);
`endif
        finish_scan("rect");

        // Whole image foreground with the weakest non-zero value
        fill(8'h01);
        run_scan(1'b0, 0, -1, lat);
        chk_box("full", 240, 0, 0, 19, 11);
`ifdef BBOX_CENTROID_EN
        chk("full_sumx", 32'(Sum_X), 32'd2280);
        chk("full_sumy", 32'(Sum_Y), 32'd1320);
`endif
        finish_scan("full");

        // Asynchronous reset in the middle of a scan
        @(negedge Clk);
        Go_s = 1'b1;
        @(posedge Clk);
        #1;
        Go_s = 1'b0;
        repeat (99) @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        chk("abort_ena",  32'(MB_ena),      32'd0);
        chk("abort_addr", 32'(MB_Addr17_2), 32'd0);
        chk("abort_done", 32'(Done_s),      32'd0);
        chk_box("abort", 0, 0, 0, 0, 0);
        @(negedge Clk);
        Rst = 1'b0;
        run_scan(1'b0, 0, 0, lat);
        chk("rescan_latency", 32'(lat), 32'(LAT));
        chk_box("rescan", 240, 0, 0, 19, 11);
        finish_scan("rescan");

        // Go held through completion: Done stays up, no restart
        run_scan(1'b1, 0, -1, lat);
        chk("hold_latency", 32'(lat), 32'(LAT));
        repeat (5) @(posedge Clk);
        #1;
        chk("hold_done", 32'(Done_s), 32'd1);
        chk("hold_ena",  32'(MB_ena), 32'd0);
        @(negedge Clk);
        Go_s = 1'b0;
        @(posedge Clk);
        #1;
        chk("hold_release_done", 32'(Done_s), 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        chk("hold_no_restart", 32'(MB_ena), 32'd0);

        // Mid-scan Go pulse ignored; empty image after non-empty forces zero box
        fill(8'h00);
        run_scan(1'b0, 50, 240, lat);
        chk("pulse_latency", 32'(lat), 32'(LAT));
        chk_box("pulse", 0, 0, 0, 0, 0);
        finish_scan("pulse");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
